// File: rtl/clock_gen_multi.sv
// clock_gen_multi: multi-channel clock-enable / divided-clock generator with a heartbeat LED counter.
// Ports: CLOCK_50 system clock; reset sync active-high; cfg_we/cfg_ch/cfg_div divisor write port;
// mode channel-0 mode (00 run, 01 debug, 10 step, 11 halt); step_req step key level;
// tick one-cycle enable per channel; clk_out divided square wave per channel; LEDR heartbeat top bits.
module clock_gen_multi #(
  parameter int NCH         = 2,
  parameter int CH_W        = 3,
  parameter int CNT_W       = 24,
  parameter int DIV_DEFAULT = 31,
  parameter int DEBUG_SHIFT = 16,
  parameter int HB_W        = 28,
  parameter int LED_W       = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [1:0]       mode,
  input  logic             step_req,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out,
  output logic [LED_W-1:0] LEDR
);
  typedef enum logic [1:0] {RUN, DEBUG, STEP, HALT} mode_t;
  mode_t                  mode_q;
  logic [CNT_W-1:0]       div [NCH];
  logic [CNT_W-1:0]       cnt [NCH];
  logic [DEBUG_SHIFT-1:0] pre;
  logic [HB_W-1:0]        hb;
  logic                   step_q;
  logic [NCH-1:0]         wr;
  logic                   step_edge, mode_chg, pre_wrap, ch0_free, ch0_pulse;
  always_comb begin
    for (int c = 0; c < NCH; c++) wr[c] = cfg_we && cfg_ch == CH_W'(c);
    step_edge = step_req && !step_q;
    mode_chg  = mode_t'(mode) != mode_q;
    pre_wrap  = &pre;
    ch0_free  = !mode_q[1];
    // a step pulse is suppressed on the cycle channel 0 reloads for run/debug
    ch0_pulse = mode_q == STEP && step_edge && mode[1];
  end
  assign LEDR = hb[HB_W-1 -: LED_W];
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q  <= RUN;
      step_q  <= 1'b1;
      pre     <= '0;
      hb      <= '0;
      tick    <= '0;
      clk_out <= '0;
      for (int c = 0; c < NCH; c++) begin
        div[c] <= CNT_W'(DIV_DEFAULT);
        cnt[c] <= CNT_W'(DIV_DEFAULT);
      end
    end else begin
      mode_q <= mode_t'(mode);
      step_q <= step_req;
      hb     <= hb + HB_W'(1);
      pre    <= mode_chg ? '0 : mode_q == DEBUG ? pre + DEBUG_SHIFT'(1) : pre;
      for (int c = 0; c < NCH; c++) begin
        if (c == 0 && !ch0_free) begin
          // step/halt: counter frozen, a write only updates the divisor; leaving reloads
          if (wr[0]) div[0] <= cfg_div;
          if (!mode[1]) cnt[0] <= wr[0] ? cfg_div : div[0];
          tick[0]    <= ch0_pulse;
          clk_out[0] <= ch0_pulse;
        end else if (wr[c]) begin
          div[c]     <= cfg_div;
          cnt[c]     <= cfg_div;
          tick[c]    <= 1'b0;
          clk_out[c] <= 1'b0;
        end else if (c == 0 && mode_q == DEBUG && !pre_wrap) begin
          tick[c] <= 1'b0;
        end else if (cnt[c] == '0) begin
          tick[c]    <= 1'b1;
          cnt[c]     <= div[c];
          clk_out[c] <= !clk_out[c];
        end else begin
          tick[c] <= 1'b0;
          cnt[c]  <= cnt[c] - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_gen_multi.sv
// tb_clock_gen_multi: scoreboard bench for clock_gen_multi; expected tick cycles are queued, a monitor pops them.
module tb_clock_gen_multi;
  localparam int NCH = 2, CH_W = 3, CNT_W = 24, HB_W = 10, LED_W = 4, B = 3;
  logic clk = 0, reset = 1, cfg_we = 0, step_req = 1;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [1:0] mode = 2'b00;
  logic [NCH-1:0] tick, clk_out;
  logic [LED_W-1:0] LEDR;
  int cyc = 0, errors = 0, checks = 0;
  int q0[$], q1[$];
  bit mon0 = 1, mon1 = 1;
  clock_gen_multi #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .DIV_DEFAULT(31), .DEBUG_SHIFT(2),
                    .HB_W(HB_W), .LED_W(LED_W)) dut (
    .CLOCK_50(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .mode(mode), .step_req(step_req), .tick(tick), .clk_out(clk_out), .LEDR(LEDR));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic at(int t);
    while (cyc < B + t) begin
      @(posedge clk);
      #2;
    end
  endtask
  always @(negedge clk) begin
    if (mon0) begin
      while (q0.size() > 0 && q0[0] < cyc) chk("tick0 missed", cyc, q0.pop_front());
      if (tick[0]) begin
        if (q0.size() == 0) chk("tick0 unexpected", cyc, -1);
        else chk("tick0 time", cyc, q0.pop_front());
      end
    end
    if (mon1) begin
      while (q1.size() > 0 && q1[0] < cyc) chk("tick1 missed", cyc, q1.pop_front());
      if (tick[1]) begin
        if (q1.size() == 0) chk("tick1 unexpected", cyc, -1);
        else chk("tick1 time", cyc, q1.pop_front());
      end
    end
  end
  initial begin
    for (int k = 1; k <= 5; k++) q0.push_back(B + 32 * k);
    for (int k = 1; k <= 3; k++) q1.push_back(B + 32 * k);
    at(0);
    reset = 0;
    step_req = 0;
    at(32);  chk("clk_out0 first toggle", int'(clk_out[0]), 1);
    at(63);  chk("LEDR before 64", int'(LEDR), 0);
    at(64);  chk("LEDR at 64", int'(LEDR), 1);
    chk("clk_out0 second toggle", int'(clk_out[0]), 0);
    at(100);
    cfg_we = 1; cfg_ch = 1; cfg_div = 0;
    for (int t = 102; t <= 109; t++) q1.push_back(B + t);
    at(101); cfg_we = 0;
    at(102); chk("clk_out1 div0 high", int'(clk_out[1]), 1);
    at(103); chk("clk_out1 div0 low", int'(clk_out[1]), 0);
    at(110); mon1 = 0;
    at(111); chk("q1 drained div0", q1.size(), 0);
    at(112); cfg_we = 1; cfg_ch = 1; cfg_div = 7;
    at(113); cfg_we = 0;
    at(114);
    for (int k = 0; k <= 38; k++) q1.push_back(B + 121 + 8 * k);
    mon1 = 1;
    at(170); cfg_we = 1; cfg_ch = 0; cfg_div = 3;
    q0.push_back(B + 175); q0.push_back(B + 179);
    at(171); cfg_we = 0;
    at(180); mode = 2'b01;
    for (int k = 0; k < 4; k++) q0.push_back(B + 189 + 16 * k);
    at(240); mode = 2'b00;
    for (int k = 0; k < 5; k++) q0.push_back(B + 244 + 4 * k);
    at(260); mode = 2'b10;
    q0.push_back(B + 266); q0.push_back(B + 281);
    at(265); step_req = 1;
    at(266); chk("clk_out0 step pulse", int'(clk_out[0]), 1);
    at(267); chk("clk_out0 step end", int'(clk_out[0]), 0);
    at(275); step_req = 0;
    at(280); step_req = 1;
    at(281); chk("clk_out0 second step", int'(clk_out[0]), 1);
    at(290); mode = 2'b11;
    for (int t = 292; t <= 390; t++) begin
      at(t);
      chk("halt tick0", int'(tick[0]), 0);
      chk("halt clk_out0", int'(clk_out[0]), 0);
      if (t == 300) begin cfg_we = 1; cfg_ch = 0; cfg_div = 5; end
      if (t == 301) cfg_we = 0;
    end
    mode = 2'b00;
    for (int k = 0; k < 5; k++) q0.push_back(B + 397 + 6 * k);
    at(397); chk("clk_out0 after halt", int'(clk_out[0]), 1);
    at(410); cfg_we = 1; cfg_ch = 7; cfg_div = 0;
    at(411); cfg_we = 0;
    at(425); reset = 1; mode = 2'b10; step_req = 1;
    at(426);
    chk("reset tick", int'(tick), 0);
    chk("reset clk_out", int'(clk_out), 0);
    chk("reset LEDR", int'(LEDR), 0);
    chk("q0 drained before reset", q0.size(), 0);
    chk("q1 drained before reset", q1.size(), 0);
    at(428); reset = 0;
    q1.push_back(B + 460);
    at(460); chk("clk_out1 after reset", int'(clk_out[1]), 1);
    at(470);
    chk("q0 empty at end", q0.size(), 0);
    chk("q1 empty at end", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
